spi_byte_receiver: RTL

SPI slave front end for the RGBW controller: oversamples the external SPI pins on the system clock, assembles MSB-first bytes, and presents each completed byte with a stretched `rdy` strobe to the downstream frame dispatcher. The dispatcher detects the rising edge of `rdy`, so this block guarantees clean, well-separated strobes and a stable byte. It also echoes the last received byte on MISO for host read-back, and flags bytes lost to overrun.

---
 rtl/spi_byte_receiver_if.sv | 23 ++
 rtl/spi_byte_receiver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spi_byte_receiver_if.sv
// Pin and byte-strobe bundle of the SPI byte receiver: raw SPI pins in, echo pin and byte strobe out.
// The master modport is the SPI host / dispatcher side, the slave modport is the receiver itself.
interface spi_byte_receiver_if;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_byte;
  logic       rdy;
  logic       overrun;
  logic       busy;

  modport master (
    output sclk, mosi, cs_n,
    input  miso, miso_oe, rx_byte, rdy, overrun, busy
  );

  modport slave (
    input  sclk, mosi, cs_n,
    output miso, miso_oe, rx_byte, rdy, overrun, busy
  );
endinterface

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave: oversampled pins, MSB-first bytes, rdy held RDY_HOLD cycles, MISO echoes last byte.
// Byte and rdy appear on the 3rd clk edge after the raw 8th sclk rise; a byte completing while rdy is high is dropped and flags overrun.
module spi_byte_receiver #(
  parameter int RDY_HOLD = 4
) (
  input logic               clk,
  input logic               reset,
  spi_byte_receiver_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } rdy_state_t;

  localparam logic [4:0] HOLD_INIT = 5'(RDY_HOLD - 1);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic cs_s1, cs_s2, cs_s3;

  logic       sclk_rise, sclk_fall;
  logic       cs_active, cs_start;
  logic       bit_rise, byte_done, accept, drop;
  logic [7:0] rx_next;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] rx_byte_q;
  logic       overrun_q;

  rdy_state_t state, state_nxt;
  logic [4:0] hold_cnt, hold_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
      cs_s1   <= bus.cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
    end
  end

  always_comb begin
    sclk_rise = sclk_s2 & ~sclk_s3;
    sclk_fall = ~sclk_s2 & sclk_s3;
    cs_active = ~cs_s2;
    cs_start  = ~cs_s2 & cs_s3;
    bit_rise  = cs_active & ~cs_start & sclk_rise;
    byte_done = bit_rise & (bit_cnt == 3'd7);
    accept    = byte_done & (state == ST_IDLE);
    drop      = byte_done & (state == ST_HOLD);
    rx_next   = {rx_shift[6:0], mosi_s2};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (!cs_active || cs_start) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (bit_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_byte_q <= 8'h00;
    end else if (accept) begin
      rx_byte_q <= rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (cs_start) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end
  end

  // The fall right after the 8th rise (bit_cnt already wrapped to 0) must not
  // shift, otherwise the freshly reloaded echo byte would lose its MSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_shift <= 8'h00;
    end else if (cs_active) begin
      if (cs_start) begin
        tx_shift <= rx_byte_q;
      end else if (accept) begin
        tx_shift <= rx_next;
      end else if (drop) begin
        tx_shift <= rx_byte_q;
      end else if (sclk_fall && bit_cnt != 3'd0) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hold_cnt <= 5'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 5'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          hold_nxt = hold_cnt - 5'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = 5'd0;
      end
    endcase
  end

  assign bus.miso    = tx_shift[7];
  assign bus.miso_oe = cs_active;
  assign bus.busy    = cs_active;
  assign bus.rx_byte = rx_byte_q;
  assign bus.rdy     = (state == ST_HOLD);
  assign bus.overrun = overrun_q;

endmodule
